// File: rtl/marquee_pkg.sv
// Shared constants for the 12-bit LED marquee bus: pattern values, symbol codes,
// the 10-step expected-symbol sequence and the monitor lock FSM state type.
package marquee_pkg;

    localparam logic [11:0] PAT_BEF = 12'hBEF;
    localparam logic [11:0] PAT_5D7 = 12'h5D7;
    localparam logic [11:0] PAT_F7D = 12'hF7D;
    localparam logic [11:0] PAT_EBA = 12'hEBA;
    localparam logic [11:0] PAT_492 = 12'h492;
    localparam logic [11:0] PAT_B6D = 12'hB6D;

    typedef logic [2:0] sym_t;

    localparam sym_t SYM_BEF = 3'd0;
    localparam sym_t SYM_5D7 = 3'd1;
    localparam sym_t SYM_F7D = 3'd2;
    localparam sym_t SYM_EBA = 3'd3;
    localparam sym_t SYM_492 = 3'd4;
    localparam sym_t SYM_B6D = 3'd5;
    localparam sym_t SYM_INV = 3'd7;

    localparam logic [3:0] LAST_STEP     = 4'd9;
    localparam logic [3:0] LOCK_STEP_492 = 4'd4;
    localparam logic [3:0] LOCK_STEP_B6D = 4'd5;

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    function automatic sym_t decode_pat(input logic [11:0] pat);
        case (pat)
            PAT_BEF: decode_pat = SYM_BEF;
            PAT_5D7: decode_pat = SYM_5D7;
            PAT_F7D: decode_pat = SYM_F7D;
            PAT_EBA: decode_pat = SYM_EBA;
            PAT_492: decode_pat = SYM_492;
            PAT_B6D: decode_pat = SYM_B6D;
            default: decode_pat = SYM_INV;
        endcase
    endfunction

    function automatic sym_t expected_sym(input logic [3:0] step);
        case (step)
            4'd0:    expected_sym = SYM_BEF;
            4'd1:    expected_sym = SYM_5D7;
            4'd2:    expected_sym = SYM_F7D;
            4'd3:    expected_sym = SYM_EBA;
            4'd4:    expected_sym = SYM_492;
            4'd5:    expected_sym = SYM_B6D;
            4'd6:    expected_sym = SYM_F7D;
            4'd7:    expected_sym = SYM_EBA;
            4'd8:    expected_sym = SYM_BEF;
            4'd9:    expected_sym = SYM_5D7;
            default: expected_sym = SYM_INV;
        endcase
    endfunction

endpackage

// File: rtl/marquee_pat_filter.sv
// Synchronizes the asynchronous marquee pattern, debounces it and pulses accept_o
// when a stable value differs from the last accepted one.
module marquee_pat_filter #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] pat_i,
    output logic        accept_o,
    output logic [11:0] acc_pat_o
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

    logic [11:0]   sync1_q, sync2_q;
    logic [11:0]   cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [11:0]   last_q, last_d;
    logic          accept_q, accept_d;
    logic          changed;

    // cnt counts samples of the candidate including the one that introduced it,
    // so acceptance fires on the STABLE_CYCLES-th equal sample.
    always_comb begin
        changed  = (sync2_q != cand_q);
        cand_d   = sync2_q;
        last_d   = last_q;
        accept_d = 1'b0;
        if (changed) begin
            cnt_d = CW'(1);
        end else if (cnt_q != CW'(STABLE_CYCLES)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if ((cnt_d == CW'(STABLE_CYCLES)) && (changed || (cnt_q != CW'(STABLE_CYCLES)))
            && (sync2_q != last_q)) begin
            accept_d = 1'b1;
            last_d   = sync2_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            last_q   <= '0;
            accept_q <= 1'b0;
        end else begin
            sync1_q  <= pat_i;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            accept_q <= accept_d;
        end
    end

    assign accept_o  = accept_q;
    assign acc_pat_o = last_q;

endmodule

// File: rtl/marquee_monitor.sv
// Receive-side marquee checker: decodes accepted patterns, locks onto the 10-step
// sequence, and reports step, sequence errors, invalid symbols and stalls.
module marquee_monitor
    import marquee_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned TIMEOUT       = 30000000,
    parameter int unsigned TO_W          = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] pat_in,
    output logic        locked,
    output logic [3:0]  step,
    output logic        step_valid,
    output logic        err_pulse,
    output logic [7:0]  err_cnt,
    output logic        sym_invalid,
    output logic        stall
);

    logic        accept;
    logic [11:0] acc_pat;

    marquee_pat_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
        .clk       (clk),
        .reset     (reset),
        .pat_i     (pat_in),
        .accept_o  (accept),
        .acc_pat_o (acc_pat)
    );

    state_t          state_q, state_d;
    logic [3:0]      step_q, step_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [7:0]      err_q, err_d;
    logic            stall_q, stall_d;
    logic            sv_q, sv_d;
    logic            ep_q, ep_d;
    logic            inv_q, inv_d;
    sym_t            sym;
    logic [3:0]      next_step;

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        to_d      = to_q;
        err_d     = err_q;
        stall_d   = stall_q;
        sv_d      = 1'b0;
        ep_d      = 1'b0;
        inv_d     = inv_q;
        sym       = decode_pat(acc_pat);
        next_step = (step_q == LAST_STEP) ? 4'd0 : step_q + 4'd1;

        // An accept always wins over a timeout expiring in the same cycle.
        if (accept) begin
            inv_d   = (sym == SYM_INV);
            stall_d = 1'b0;
            to_d    = '0;
            case (state_q)
                UNLOCKED: begin
                    if (sym == SYM_492) begin
                        state_d = LOCKED;
                        step_d  = LOCK_STEP_492;
                        sv_d    = 1'b1;
                    end else if (sym == SYM_B6D) begin
                        state_d = LOCKED;
                        step_d  = LOCK_STEP_B6D;
                        sv_d    = 1'b1;
                    end
                end
                LOCKED: begin
                    if (sym == expected_sym(next_step)) begin
                        step_d = next_step;
                        sv_d   = 1'b1;
                    end else begin
                        ep_d    = 1'b1;
                        err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
                        state_d = UNLOCKED;
                        step_d  = '0;
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end else if (state_q == LOCKED) begin
            if (to_q == TO_W'(TIMEOUT - 1)) begin
                stall_d = 1'b1;
                state_d = UNLOCKED;
                step_d  = '0;
                to_d    = '0;
            end else begin
                to_d = to_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= UNLOCKED;
            step_q  <= '0;
            to_q    <= '0;
            err_q   <= '0;
            stall_q <= 1'b0;
            sv_q    <= 1'b0;
            ep_q    <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            to_q    <= to_d;
            err_q   <= err_d;
            stall_q <= stall_d;
            sv_q    <= sv_d;
            ep_q    <= ep_d;
            inv_q   <= inv_d;
        end
    end

    assign locked      = (state_q == LOCKED);
    assign step        = step_q;
    assign step_valid  = sv_q;
    assign err_pulse   = ep_q;
    assign err_cnt     = err_q;
    assign sym_invalid = inv_q;
    assign stall       = stall_q;

endmodule

// File: tb/tb_marquee_monitor.sv
// Self-checking bench for marquee_monitor against a sequence-level reference model.
module tb_marquee_monitor;

    logic        clk;
    logic        reset;
    logic [11:0] pat_in;
    logic        locked;
    logic [3:0]  step;
    logic        step_valid;
    logic        err_pulse;
    logic [7:0]  err_cnt;
    logic        sym_invalid;
    logic        stall;

    marquee_monitor #(.STABLE_CYCLES(4), .TIMEOUT(64), .TO_W(7)) dut (
        .clk         (clk),
        .reset       (reset),
        .pat_in      (pat_in),
        .locked      (locked),
        .step        (step),
        .step_valid  (step_valid),
        .err_pulse   (err_pulse),
        .err_cnt     (err_cnt),
        .sym_invalid (sym_invalid),
        .stall       (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: pattern table, expected-symbol sequence, tracked position.
    logic [11:0] TBL [6] = '{12'hBEF, 12'h5D7, 12'hF7D, 12'hEBA, 12'h492, 12'hB6D};
    int          SEQ [10] = '{0, 1, 2, 3, 4, 5, 2, 3, 0, 1};
    logic [11:0] m_last;
    bit          m_locked, m_inv, m_stall, m_sv, m_ep;
    int          m_step, m_errs;

    function automatic int sym_of(input logic [11:0] p);
        for (int i = 0; i < 6; i++) if (TBL[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_last = 12'h000; m_locked = 0; m_inv = 0; m_stall = 0;
        m_sv = 0; m_ep = 0; m_step = 0; m_errs = 0;
    endtask

    task automatic model_accept(input logic [11:0] p);
        int s;
        m_sv = 0; m_ep = 0;
        if (p == m_last) return;
        m_last  = p;
        s       = sym_of(p);
        m_inv   = (s < 0);
        m_stall = 0;
        if (!m_locked) begin
            if (s == 4 || s == 5) begin m_locked = 1; m_step = s; m_sv = 1; end
        end else if (s == SEQ[(m_step + 1) % 10]) begin
            m_step = (m_step + 1) % 10; m_sv = 1;
        end else begin
            m_ep = 1; m_locked = 0; m_step = 0;
            if (m_errs < 255) m_errs++;
        end
    endtask

    function automatic logic [18:0] exp_vec();
        return {2'b00, m_sv, m_ep, m_locked, 4'(m_step), 8'(m_errs), m_inv, m_stall};
    endfunction

    // Snapshot taken by apply: pulses one edge early/late, full state at the expected edge.
    logic        obs_pre, obs_post;
    logic [16:0] obs_mid;

    function automatic logic [18:0] obs_vec();
        return {obs_pre, obs_post, obs_mid};
    endfunction

    task automatic apply(input logic [11:0] p, input int hold);
        @(negedge clk);
        pat_in = p;
        for (int k = 1; k <= hold; k++) begin
            @(posedge clk); #1;
            if (k == 6) obs_pre = step_valid | err_pulse;
            if (k == 7) obs_mid = {step_valid, err_pulse, locked, step, err_cnt, sym_invalid, stall};
            if (k == 8) obs_post = step_valid | err_pulse;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; pat_in = 12'h000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({locked, step, step_valid, err_pulse, err_cnt, sym_invalid, stall} !== 17'h0) begin
            n_bad++;
            $display("FAIL reset_state: got %h want 0",
                     {locked, step, step_valid, err_pulse, err_cnt, sym_invalid, stall});
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_loop();
        for (int i = 0; i < 20; i++) begin
            model_accept(TBL[SEQ[i % 10]]);
            apply(TBL[SEQ[i % 10]], 20);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL loop[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_seq_error();
        logic [11:0] pats [8] = '{12'hBEF, 12'h5D7, 12'hF7D, 12'hEBA, 12'h492, 12'hB6D,
                                  12'hF7D, 12'h492};
        for (int i = 0; i < 8; i++) begin
            model_accept(pats[i]);
            apply(pats[i], 12);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL seq_error[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        model_accept(12'h492);
        apply(12'h492, 20);
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL glitch_relock: got %h want %h", obs_vec(), exp_vec());
        end
        @(negedge clk); pat_in = 12'h5D7;
        repeat (3) @(negedge clk);
        pat_in = 12'h492;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            pulses += int'(step_valid | err_pulse);
        end
        n_vec++;
        if (pulses != 0 || {locked, step, err_cnt} !== {m_locked, 4'(m_step), 8'(m_errs)}) begin
            n_bad++;
            $display("FAIL glitch: got pulses=%0d state=%h want pulses=0 state=%h", pulses,
                     {locked, step, err_cnt}, {m_locked, 4'(m_step), 8'(m_errs)});
        end
    endtask

    task automatic test_timeout();
        model_accept(12'hB6D); apply(12'hB6D, 12);
        model_accept(12'hF7D); apply(12'hF7D, 8);
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL timeout_setup: got %h want %h", obs_vec(), exp_vec());
        end
        repeat (62) @(posedge clk);
        #1;
        n_vec++;
        if ({stall, locked} !== 2'b01) begin
            n_bad++;
            $display("FAIL timeout_early: got stall,locked=%b want 01", {stall, locked});
        end
        @(posedge clk); #1;
        m_stall = 1; m_locked = 0; m_step = 0;
        n_vec++;
        if ({stall, locked, step, err_cnt} !== {m_stall, m_locked, 4'(m_step), 8'(m_errs)}) begin
            n_bad++;
            $display("FAIL timeout_stall: got %h want %h", {stall, locked, step, err_cnt},
                     {m_stall, m_locked, 4'(m_step), 8'(m_errs)});
        end
        repeat (6) @(posedge clk);
        #1;
        n_vec++;
        if (stall !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_held: got %b want 1", stall);
        end
        model_accept(12'hB6D);
        apply(12'hB6D, 12);
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL stall_recover: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_invalid();
        model_accept(12'h123);
        apply(12'h123, 10);
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL invalid: got %h want %h", obs_vec(), exp_vec());
        end
        for (int i = 0; i < 260; i++) begin
            model_accept(12'h492); apply(12'h492, 8);
            model_accept(12'h123); apply(12'h123, 8);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL err_sat[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_vec++;
        if (err_cnt !== 8'd255) begin
            n_bad++;
            $display("FAIL err_cnt_sat: got %0d want 255", err_cnt);
        end
    endtask

    task automatic test_random();
        logic [11:0] p;
        for (int i = 0; i < 200; i++) begin
            if (m_locked && $urandom_range(3) != 0) begin
                p = TBL[SEQ[(m_step + 1) % 10]];
            end else if ($urandom_range(7) == 0) begin
                p = 12'($urandom);
            end else begin
                p = TBL[$urandom_range(5)];
            end
            if (p == m_last) p = p ^ 12'h001;
            model_accept(p);
            apply(p, 8 + $urandom_range(12));
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random[%0d] pat=%h: got %h want %h", i, p, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] held;
        int pulses = 0;
        if (!m_locked) begin
            held = (m_last != 12'h492) ? 12'h492 : 12'hB6D;
            model_accept(held); apply(held, 12);
        end
        held = m_last;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++;
        if ({locked, step, step_valid, err_pulse, err_cnt, sym_invalid, stall} !== 17'h0) begin
            n_bad++;
            $display("FAIL reset_mid: got %h want 0",
                     {locked, step, step_valid, err_pulse, err_cnt, sym_invalid, stall});
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_reset();
        model_accept(held);
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (k == 6) obs_pre = step_valid | err_pulse;
            if (k == 7) obs_mid = {step_valid, err_pulse, locked, step, err_cnt, sym_invalid, stall};
            if (k == 8) obs_post = step_valid | err_pulse;
            if (k > 8) pulses += int'(step_valid | err_pulse);
        end
        n_vec++;
        if (obs_vec() !== exp_vec() || pulses != 0) begin
            n_bad++;
            $display("FAIL reset_release: got %h extra=%0d want %h extra=0", obs_vec(), pulses,
                     exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_loop();
        test_seq_error();
        test_glitch();
        test_timeout();
        test_invalid();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
